// File: rtl/matrix_scan_driver.sv
// Row-scanned LED matrix driver: shifts a snapshot row out to a colour shift-register chain,
// latches it, then enables that row for a fixed dwell before moving to the next.
module matrix_scan_driver #(
  parameter int unsigned DIV   = 2,
  parameter int unsigned DWELL = 4000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [7:0][23:0] frame,
  output logic             ser_data,
  output logic             ser_clk,
  output logic             ser_latch,
  output logic [7:0]       row_sel,
  output logic             frame_start
);

  typedef enum logic [2:0] {StIdle, StLoad, StShift, StLatch, StDisplay} state_e;

  state_e           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             half_q, half_d;
  logic [4:0]       bit_q, bit_d;
  logic [2:0]       row_q, row_d;
  logic [7:0][23:0] snap_q, snap_d;

  logic div_last, shift_done, latch_done, disp_done;

  assign div_last   = (cnt_q == 16'(DIV - 1));
  assign shift_done = (state_q == StShift) && div_last && half_q && (bit_q == 5'd23);
  assign latch_done = (state_q == StLatch) && div_last;
  assign disp_done  = (state_q == StDisplay) && (cnt_q == 16'(DWELL - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (en) state_d = StLoad;
      StLoad:    state_d = StShift;
      StShift:   if (shift_done) state_d = StLatch;
      StLatch:   if (latch_done) state_d = StDisplay;
      StDisplay: begin
        if (disp_done) begin
          if (!en)                 state_d = StIdle;
          else if (row_q == 3'd7)  state_d = StLoad;
          else                     state_d = StShift;
        end
      end
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    ser_data    = 1'b0;
    ser_clk     = 1'b0;
    ser_latch   = 1'b0;
    frame_start = 1'b0;
    row_sel     = 8'hFF;
    unique case (state_q)
      StLoad:    frame_start = 1'b1;
      StShift: begin
        ser_data = snap_q[row_q][5'd23 - bit_q];
        ser_clk  = half_q;
      end
      StLatch:   ser_latch = 1'b1;
      StDisplay: row_sel = ~(8'b1 << row_q);
      default:   ;
    endcase
  end

  // Phase counter restarts at every phase boundary so no phase ever relies on wraparound.
  always_comb begin
    cnt_d  = cnt_q + 16'd1;
    half_d = half_q;
    bit_d  = bit_q;
    row_d  = row_q;
    snap_d = snap_q;
    unique case (state_q)
      StIdle: begin
        cnt_d  = '0;
        half_d = 1'b0;
        bit_d  = '0;
      end
      StLoad: begin
        cnt_d  = '0;
        snap_d = frame;
        row_d  = '0;
      end
      StShift: begin
        if (div_last) begin
          cnt_d  = '0;
          half_d = ~half_q;
          if (half_q) bit_d = shift_done ? 5'd0 : bit_q + 5'd1;
        end
      end
      StLatch:   if (latch_done) cnt_d = '0;
      StDisplay: begin
        if (disp_done) begin
          cnt_d = '0;
          if (en) row_d = row_q + 3'd1;
        end
      end
      default:   cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q  <= '0;
      half_q <= 1'b0;
      bit_q  <= '0;
      row_q  <= '0;
      snap_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      half_q <= half_d;
      bit_q  <= bit_d;
      row_q  <= row_d;
      snap_q <= snap_d;
    end
  end

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Directed frame sequence with random frame contents, checked cycle by cycle against a
// row-timeline model of the scan (shift, latch, dwell) computed from plain arithmetic.
module tb_matrix_scan_driver;
  localparam int unsigned DIV   = 2;
  localparam int unsigned DWELL = 10;
  localparam int          ROWP  = 48 * DIV + DIV + DWELL;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [7:0][23:0] frame;
  logic             ser_data, ser_clk, ser_latch, frame_start;
  logic [7:0]       row_sel;

  matrix_scan_driver #(.DIV(DIV), .DWELL(DWELL)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .frame      (frame),
    .ser_data   (ser_data),
    .ser_clk    (ser_clk),
    .ser_latch  (ser_latch),
    .row_sel    (row_sel),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int               compared   = 0;
  int               mismatched = 0;
  int               cyc        = 0;
  int               last_fs    = -1;
  int               rel_start  = -1;
  logic             prev_latch = 1'b0;
  logic [7:0]       prev_rs    = 8'hFF;
  logic [7:0][23:0] model_snap;
  logic [7:0][23:0] pending;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next sampling point and track row release -> latch release spacing.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (row_sel == 8'hFF && prev_rs != 8'hFF) rel_start = cyc;
    if (prev_latch && !ser_latch && rel_start >= 0) begin
      chk("latch_gap", 32'(cyc - rel_start), 32'(48 * DIV + DIV));
      rel_start = -1;
    end
    prev_latch = ser_latch;
    prev_rs    = row_sel;
  endtask

  function automatic logic [11:0] bundle();
    return {ser_data, ser_clk, ser_latch, frame_start, row_sel};
  endfunction

  function automatic logic [11:0] exp_row(input int r, input logic [23:0] d, input int t);
    int b;
    if (t < 48 * DIV) begin
      b = t / (2 * DIV);
      return {d[23 - b], ((t % (2 * DIV)) >= DIV), 1'b0, 1'b0, 8'hFF};
    end
    if (t < 49 * DIV) return {4'b0010, 8'hFF};
    return {4'b0000, ~(8'(1) << r)};
  endfunction

  task automatic check_idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk("idle", 32'(bundle()), 32'({4'b0000, 8'hFF}));
    end
  endtask

  task automatic check_load(input bit check_period);
    step();
    chk("load", 32'(bundle()), 32'({4'b0001, 8'hFF}));
    if (check_period) chk("frame_period", 32'(cyc - last_fs), 32'(8 * ROWP + 1));
    last_fs    = cyc;
    model_snap = frame;
    rel_start  = -1;
  endtask

  // act: 1 = load pending frame, 2 = drop en, 3 = assert reset and abandon the row
  task automatic check_row(input int r, input int act_t, input int act);
    logic [23:0] d;
    logic [23:0] cap;
    logic        pclk;
    int          run;
    d    = model_snap[r];
    cap  = '0;
    pclk = 1'b0;
    run  = 0;
    for (int t = 0; t < ROWP; t++) begin
      step();
      chk($sformatf("row%0d_t%0d", r, t), 32'(bundle()), 32'(exp_row(r, d, t)));
      if (ser_clk && !pclk) cap = {cap[22:0], ser_data};
      if (t == 0) run = 1;
      else if (ser_clk != pclk) begin
        if (t <= 48 * DIV) chk($sformatf("ser_clk_width_r%0d_t%0d", r, t), 32'(run), 32'(DIV));
        run = 1;
      end else run++;
      pclk = ser_clk;
      if (t == act_t) begin
        case (act)
          1: frame = pending;
          2: en = 1'b0;
          3: begin
            reset = 1'b0;
            return;
          end
          default: ;
        endcase
      end
    end
    chk($sformatf("row%0d_bits", r), 32'(cap), 32'(d));
  endtask

  task automatic randomize_frame();
    for (int r = 0; r < 8; r++) frame[r] = 24'($urandom);
  endtask

  initial begin
    reset = 1'b0;
    en    = 1'b0;
    randomize_frame();
    check_idle(3);
    reset = 1'b1;
    check_idle(4);

    // Frame 1: row 0 fixed, mid-frame change must not tear rows 4..7
    randomize_frame();
    frame[0] = 24'hA5A5A5;
    for (int r = 0; r < 8; r++) pending[r] = 24'(r * 24'h111111);
    en = 1'b1;
    check_load(1'b0);
    for (int r = 0; r < 8; r++) check_row(r, (r == 3) ? 50 : -1, (r == 3) ? 1 : 0);

    // Frame 2: r*111111 pattern; switch to all ones during row 3
    for (int r = 0; r < 8; r++) pending[r] = 24'hFFFFFF;
    check_load(1'b1);
    for (int r = 0; r < 8; r++) check_row(r, (r == 3) ? 20 : -1, (r == 3) ? 1 : 0);

    // Frame 3: en dropped 5 cycles into row 2 dwell
    check_load(1'b1);
    check_row(0, -1, 0);
    check_row(1, -1, 0);
    check_row(2, 48 * DIV + DIV + 4, 2);
    check_idle(20);

    // Frame 4: reset in bit 12 of row 5
    randomize_frame();
    en = 1'b1;
    check_load(1'b0);
    for (int r = 0; r < 5; r++) check_row(r, -1, 0);
    check_row(5, 12 * 2 * DIV + 1, 3);
    check_idle(5);
    randomize_frame();
    reset = 1'b1;
    check_load(1'b0);
    check_row(0, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/matrix_scan_driver.md
MATRIX_SCAN_DRIVER -- requirements
Module: matrix_scan_driver

Interface
REQ-001 Parameter DIV, default 2: serial half-period in clk cycles; legal range 1..255.
REQ-002 Parameter DWELL, default 4000: row on-time in clk cycles; legal range 1..65535.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 en  input  1  scan enable, sampled only at row boundaries.
REQ-006 frame  input  [7:0][23:0]  frame from the game state controller; frame[r] is row r; pixel c of row r is frame[r][3c+2:3c] = {R,G,B}.
REQ-007 ser_data  output  1  serial colour bit to the column shift-register chain.
REQ-008 ser_clk  output  1  shift clock; the chain samples ser_data on its rising edge.
REQ-009 ser_latch  output  1  storage-register latch strobe, active high.
REQ-010 row_sel  output  [7:0]  row drivers, active-low one-hot; all ones means blanked.
REQ-011 frame_start  output  1  one-cycle pulse when a new frame snapshot is taken.

Function
REQ-012 States SHALL be IDLE, LOAD, SHIFT, LATCH and DISPLAY; the row counter is 3 bits (0..7).
REQ-013 IDLE: all outputs low except row_sel = 8'hFF; go to LOAD on the cycle en is sampled high.
REQ-014 LOAD lasts 1 cycle: copy all of frame into an internal snapshot, pulse frame_start, set row to 0, go to SHIFT.
REQ-015 Display data SHALL come only from the snapshot; changes to frame during a frame have no visible effect until the next LOAD (no tearing).
REQ-016 SHIFT sends snapshot[row] MSB first (bit 23 down to bit 0), 24 bits in total.
REQ-017 Each bit: ser_clk low for DIV cycles, then high for DIV cycles; ser_data is stable for the whole bit and changes only on the cycle ser_clk goes low.
REQ-018 SHIFT SHALL last exactly 48*DIV cycles, then go to LATCH.
REQ-019 LATCH: ser_latch high and ser_clk low for DIV cycles, then go to DISPLAY.
REQ-020 row_sel SHALL be 8'hFF throughout LOAD, SHIFT and LATCH.
REQ-021 DISPLAY: row_sel[row] = 0 and all other bits = 1 for exactly DWELL cycles.
REQ-022 End of DISPLAY with en low: go to IDLE; the current row always completes, so en is never acted on mid-row.
REQ-023 End of DISPLAY with en high and row < 7: increment row and go to SHIFT.
REQ-024 End of DISPLAY with en high and row = 7: wrap row to 0 and go to LOAD.
REQ-025 Row period SHALL be 48*DIV + DIV + DWELL cycles; frame period SHALL be 8 row periods plus 1 cycle.
REQ-026 All counters SHALL be sized for the maximum parameter values and SHALL never wrap inside a phase.

Reset
REQ-027 When reset = 0 at a clock edge, on the next cycle:
- state = IDLE, row = 0, snapshot = 0
- ser_data = ser_clk = ser_latch = frame_start = 0
- row_sel = 8'hFF
REQ-028 Reset SHALL take priority over every other event, including mid-SHIFT and mid-DISPLAY; no partial latch pulse may follow it.
REQ-029 After reset is released, the block stays in IDLE until en is sampled high.

Verification (DIV=2, DWELL=10, row period 108)
REQ-030 Basic frame: en=1, frame[0]=24'hA5A5A5 -> frame_start pulses once; the 24 bits captured on ser_clk rising edges = A5A5A5; ser_latch is high 2 cycles; row_sel = 8'hFE for 10 cycles.
REQ-031 Full frame: each frame[r] = r*24'h111111 -> rows 0..7 each show their pattern with the matching one-hot row_sel; frame_start pulses are 865 cycles apart.
REQ-032 No tearing: frame changed to all ones during row 3 -> rows 4..7 still show the old data; new data appears only after the next frame_start.
REQ-033 Disable: en dropped 5 cycles into DISPLAY of row 2 -> row 2 finishes all 10 cycles, then IDLE with row_sel = 8'hFF; no further ser_clk edges.
REQ-034 Reset mid-SHIFT: reset=0 at bit 12 of row 5 -> next cycle all outputs at their reset values; no ser_latch pulse; with en=1 after release, the restart begins with LOAD at row 0.
REQ-035 Timing check: the monitor measures ser_clk high and low widths (2 cycles each) and the gap between row_sel deassertion and the next ser_latch (98 cycles) -> all values exact.
